// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared constants and types for the programmable clock divider family.
//   DIV_W_DEFAULT : default counter / divisor width
//   DIV_MIN       : smallest divisor accepted by a load
//   div_vec_t     : divisor vector at the default width
// -----------------------------------------------------------------------------
package clk_div_pkg;

    localparam int DIV_W_DEFAULT = 16;
    localparam int DIV_MIN       = 2;

    typedef logic [DIV_W_DEFAULT-1:0] div_vec_t;

endpackage

// File: rtl/clk_div_odd50.sv
// -----------------------------------------------------------------------------
// clk_div_odd50
// Retimes the posedge divider output onto the falling edge of clk.
//   - Odd divisor: the output is the AND of both copies, which delays the
//     rising edge by half a clk period and gives an exact 50% duty cycle.
//   - Even divisor: the posedge copy passes straight through.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset (applied on the falling edge)
//   clk_pos  in   registered divider output from the posedge domain
//   odd      in   1 when the active divisor is odd
//   clk_out  out  duty-corrected divided clock
// -----------------------------------------------------------------------------
module clk_div_odd50 (
    input  logic clk,
    input  logic rst,
    input  logic clk_pos,
    input  logic odd,
    output logic clk_out
);

    logic clk_neg;

    always_ff @(negedge clk) begin
        if (rst) begin
            clk_neg <= 1'b0;
        end else begin
            clk_neg <= clk_pos;
        end
    end

    assign clk_out = odd ? (clk_pos & clk_neg) : clk_pos;

endmodule

// File: rtl/clk_div_prog.sv
// -----------------------------------------------------------------------------
// clk_div_prog
// Runtime-programmable integer clock divider. A new divisor is staged in a
// shadow register and only becomes active at a period boundary, so the high
// and low phases are never truncated.
// Optional build macro: CLK_DIV_PROG_ODD50_EN (exact 50% duty for odd divisors
// using a falling-edge retimer; off by default).
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   en       in   count enable; low freezes counter, clk_out and pend
//   load     in   one-cycle strobe requesting a new divisor
//   div_in   in   requested divisor, sampled when load=1
//   clk_out  out  divided clock (registered)
//   tick     out  one-cycle pulse in the cycle where the counter is back at 0
//   pend     out  a valid divisor is staged and waits for the next wrap
//   err      out  one-cycle pulse when a load with div_in < 2 is rejected
//   div_cur  out  divisor currently in effect
// -----------------------------------------------------------------------------
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DEFAULT,
    parameter int DIV_DEFAULT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [DIV_W-1:0] div_in,
    output logic             clk_out,
    output logic             tick,
    output logic             pend,
    output logic             err,
    output logic [DIV_W-1:0] div_cur
);

    localparam logic [DIV_W-1:0] DIV_MIN_V = DIV_W'(DIV_MIN);
    localparam logic [DIV_W-1:0] DIV_DEF_V = DIV_W'(DIV_DEFAULT);

    logic [DIV_W-1:0] cnt, cnt_nxt;
    logic [DIV_W-1:0] div_act, div_nxt;
    logic [DIV_W-1:0] div_shd, shd_nxt;
    logic [DIV_W-1:0] div_m1;
    logic             pend_nxt;
    logic             clk_q, clk_nxt;
    logic             wrap;
    logic             div_ok;
    logic             load_ok;

    // >= rather than == keeps the counter bounded even if cnt ever sits
    // above the last count of the active divisor.
    assign div_m1  = div_act - DIV_W'(1);
    assign wrap    = en && (cnt >= div_m1);
    assign div_ok  = (div_in >= DIV_MIN_V);
    assign load_ok = load && div_ok;

    always_comb begin
        cnt_nxt  = cnt;
        div_nxt  = div_act;
        shd_nxt  = div_shd;
        pend_nxt = pend;
        if (en) begin
            if (wrap) begin
                cnt_nxt  = '0;
                pend_nxt = 1'b0;
                // A load landing on the wrap bypasses the shadow and wins
                // over an older staged value.
                if (load_ok) begin
                    div_nxt = div_in;
                end else if (pend) begin
                    div_nxt = div_shd;
                end
            end else begin
                cnt_nxt = cnt + DIV_W'(1);
                if (load_ok) begin
                    shd_nxt  = div_in;
                    pend_nxt = 1'b1;
                end
            end
        end
        // Output is derived from the post-edge count and divisor so that a
        // fresh period always begins in the low phase.
        clk_nxt = en ? (cnt_nxt >= (div_nxt >> 1)) : clk_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            div_act <= DIV_DEF_V;
            div_shd <= DIV_DEF_V;
            pend    <= 1'b0;
            clk_q   <= 1'b0;
            tick    <= 1'b0;
            err     <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            div_act <= div_nxt;
            div_shd <= shd_nxt;
            pend    <= pend_nxt;
            clk_q   <= clk_nxt;
            tick    <= wrap;
            err     <= load && !div_ok;
        end
    end

    assign div_cur = div_act;

`ifdef CLK_DIV_PROG_ODD50_EN
    clk_div_odd50 u_odd50 (
        .clk     (clk),
        .rst     (rst),
        .clk_pos (clk_q),
        .odd     (div_act[0]),
        .clk_out (clk_out)
    );
`else
    assign clk_out = clk_q;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
`timescale 1ns/100ps
// -----------------------------------------------------------------------------
// tb_clk_div_prog
// Behavioural model: each period is queued as its sequence of output samples
// (floor(D/2) lows then ceil(D/2) highs). Every enabled clock consumes one
// sample; when a period is used up the next one starts with the last valid
// divisor loaded during the old period, or the old divisor if none.
// -----------------------------------------------------------------------------
module tb_clk_div_prog;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         load;
  logic [W-1:0] div_in;
  logic         clk_out;
  logic         tick;
  logic         pend;
  logic         err;
  logic [W-1:0] div_cur;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  logic         exp_q[$];
  logic [W-1:0] m_d;
  logic [W-1:0] m_stg;
  logic         m_stg_v;
  logic         m_clk;
  logic         m_prev;
  logic         m_tick;
  logic         m_err;

  clk_div_prog #(.DIV_W(W), .DIV_DEFAULT(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .load    (load),
    .div_in  (div_in),
    .clk_out (clk_out),
    .tick    (tick),
    .pend    (pend),
    .err     (err),
    .div_cur (div_cur)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  task automatic push_period(input logic [W-1:0] d);
    int lo;
    lo = int'(d) / 2;
    for (int i = 0; i < lo; i++) exp_q.push_back(1'b0);
    for (int i = lo; i < int'(d); i++) exp_q.push_back(1'b1);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_d     = 16'd4;
    m_stg   = 16'd4;
    m_stg_v = 1'b0;
    m_tick  = 1'b0;
    m_err   = 1'b0;
    push_period(m_d);
    m_clk   = exp_q[0];
    m_prev  = 1'b0;
  endtask

  // value expected on the clk_out port, sampled just after a rising edge
  function automatic logic port_clk();
`ifdef CLK_DIV_PROG_ODD50_EN
    return m_d[0] ? (m_clk & m_prev) : m_clk;
`else
    return m_clk;
`endif
  endfunction

  // ---------------- driver ----------------
  task automatic cycle(input logic e, input logic l, input logic [W-1:0] d);
    en = e; load = l; div_in = d;
    @(posedge clk); #1;
    m_err  = l && (d < 16'd2);
    m_tick = 1'b0;
    m_prev = m_clk;
    if (e) begin
      if (l && d >= 16'd2) begin
        m_stg   = d;
        m_stg_v = 1'b1;
      end
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) begin
        if (m_stg_v) m_d = m_stg;
        m_stg_v = 1'b0;
        push_period(m_d);
        m_tick = 1'b1;
      end
    end
    m_clk = exp_q[0];
    load = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; en = 1'b1; load = 1'b1; div_in = 16'd9;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({clk_out, tick, pend, err, div_cur} !== {1'b0, 1'b0, 1'b0, 1'b0, 16'd4}) begin
        n_bad++;
        $display("FAIL reset: clk_out=%b tick=%b pend=%b err=%b div_cur=%0d, required 0 0 0 0 4",
                 clk_out, tick, pend, err, div_cur);
      end
    end
    load = 1'b0;
    rst  = 1'b0;
    model_reset();
  endtask

  task automatic test_default();
    int ticks = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b0, 16'd0);
      if (tick === 1'b1) ticks++;
      n_cmp++;
      if ({clk_out, tick, pend, err, div_cur} !== {port_clk(), m_tick, m_stg_v, m_err, m_d}) begin
        n_bad++;
        $display("FAIL default cyc%0d: got %b %b %b %b %0d, required %b %b %b %b %0d", i,
                 clk_out, tick, pend, err, div_cur, port_clk(), m_tick, m_stg_v, m_err, m_d);
      end
    end
    n_cmp++;
    if (ticks != 3) begin
      n_bad++;
      $display("FAIL default_ticks: got %0d ticks in 12 cycles, required 3", ticks);
    end
  endtask

  task automatic test_mid_load();
    for (int i = 0; i < 28; i++) begin
      if (i < 8 && exp_q.size() != 3) cycle(1'b1, 1'b0, 16'd0);
      else if (i < 8) begin cycle(1'b1, 1'b1, 16'd6); i = 8; end
      else cycle(1'b1, 1'b0, 16'd0);
      n_cmp++;
      if ({clk_out, tick, pend, err, div_cur} !== {port_clk(), m_tick, m_stg_v, m_err, m_d}) begin
        n_bad++;
        $display("FAIL mid_load cyc%0d: got %b %b %b %b %0d, required %b %b %b %b %0d", i,
                 clk_out, tick, pend, err, div_cur, port_clk(), m_tick, m_stg_v, m_err, m_d);
      end
    end
    n_cmp++;
    if (div_cur !== 16'd6) begin
      n_bad++;
      $display("FAIL mid_load_div: div_cur=%0d, required 6", div_cur);
    end
  endtask

  task automatic test_wrap_load();
    for (int i = 0; i < 8 && exp_q.size() != 1; i++) begin
      cycle(1'b1, 1'b0, 16'd0);
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, (i == 0), 16'd3);
      n_cmp++;
      if ({clk_out, tick, pend, err, div_cur} !== {port_clk(), m_tick, m_stg_v, m_err, m_d}) begin
        n_bad++;
        $display("FAIL wrap_load cyc%0d: got %b %b %b %b %0d, required %b %b %b %b %0d", i,
                 clk_out, tick, pend, err, div_cur, port_clk(), m_tick, m_stg_v, m_err, m_d);
      end
    end
    n_cmp++;
    if (div_cur !== 16'd3) begin
      n_bad++;
      $display("FAIL wrap_load_div: div_cur=%0d, required 3", div_cur);
    end
  endtask

  task automatic test_illegal();
    int errs = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, (i < 2), (i == 0) ? 16'd1 : 16'd0);
      if (err === 1'b1) errs++;
      n_cmp++;
      if ({clk_out, tick, pend, err, div_cur} !== {port_clk(), m_tick, m_stg_v, m_err, m_d}) begin
        n_bad++;
        $display("FAIL illegal cyc%0d: got %b %b %b %b %0d, required %b %b %b %b %0d", i,
                 clk_out, tick, pend, err, div_cur, port_clk(), m_tick, m_stg_v, m_err, m_d);
      end
    end
    n_cmp++;
    if (errs != 2 || div_cur !== 16'd3) begin
      n_bad++;
      $display("FAIL illegal_sum: err pulses=%0d div_cur=%0d, required 2 and 3", errs, div_cur);
    end
  endtask

  task automatic test_enable();
    logic frz_clk;
    logic frz_pend;
    // stage a divisor so that the frozen pend flag is visible
    for (int i = 0; i < 8 && exp_q.size() != int'(m_d); i++) cycle(1'b1, 1'b0, 16'd0);
    cycle(1'b1, 1'b1, 16'd5);
    cycle(1'b1, 1'b0, 16'd0);
    frz_clk  = clk_out;
    frz_pend = pend;
    for (int i = 0; i < 15; i++) begin
      cycle((i >= 5), 1'b0, 16'd0);
      n_cmp++;
      if ({clk_out, tick, pend, err, div_cur} !== {port_clk(), m_tick, m_stg_v, m_err, m_d}) begin
        n_bad++;
        $display("FAIL enable cyc%0d: got %b %b %b %b %0d, required %b %b %b %b %0d", i,
                 clk_out, tick, pend, err, div_cur, port_clk(), m_tick, m_stg_v, m_err, m_d);
      end
      if (i < 5) begin
        n_cmp++;
        if ({clk_out, pend, tick} !== {frz_clk, frz_pend, 1'b0}) begin
          n_bad++;
          $display("FAIL enable_frozen cyc%0d: clk_out=%b pend=%b tick=%b, required %b %b 0",
                   i, clk_out, pend, tick, frz_clk, frz_pend);
        end
      end
    end
  endtask

  task automatic test_random();
    logic         e;
    logic         l;
    logic [W-1:0] d;
    for (int i = 0; i < 400; i++) begin
      e = ($urandom_range(0, 7) != 0);
      l = e && ($urandom_range(0, 9) == 0);
      d = W'($urandom_range(0, 9));
      cycle(e, l, d);
      n_cmp++;
      if ({clk_out, tick, pend, err, div_cur} !== {port_clk(), m_tick, m_stg_v, m_err, m_d}) begin
        n_bad++;
        $display("FAIL random cyc%0d: got %b %b %b %b %0d, required %b %b %b %b %0d", i,
                 clk_out, tick, pend, err, div_cur, port_clk(), m_tick, m_stg_v, m_err, m_d);
      end
    end
  endtask

  task automatic test_reset_mid();
    // leave a divisor pending mid-period, then reset over it
    cycle(1'b1, 1'b1, 16'd7);
    if (exp_q.size() == 1) cycle(1'b1, 1'b1, 16'd7);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      en = 1'b1; load = 1'b1; div_in = 16'd8;
      @(posedge clk); #1;
      n_cmp++;
      if ({clk_out, tick, pend, err, div_cur} !== {1'b0, 1'b0, 1'b0, 1'b0, 16'd4}) begin
        n_bad++;
        $display("FAIL reset_mid: clk_out=%b tick=%b pend=%b err=%b div_cur=%0d, required 0 0 0 0 4",
                 clk_out, tick, pend, err, div_cur);
      end
    end
    load = 1'b0;
    rst  = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 16'd0);
      n_cmp++;
      if ({clk_out, tick, pend, err, div_cur} !== {port_clk(), m_tick, m_stg_v, m_err, m_d}) begin
        n_bad++;
        $display("FAIL reset_mid_after cyc%0d: got %b %b %b %b %0d, required %b %b %b %b %0d", i,
                 clk_out, tick, pend, err, div_cur, port_clk(), m_tick, m_stg_v, m_err, m_d);
      end
    end
  endtask

`ifdef CLK_DIV_PROG_ODD50_EN
  task automatic test_odd50();
    int hi_ns = 0;
    cycle(1'b1, 1'b1, 16'd5);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 16'd0);
    // two full 50 ns periods sampled every ns: exactly half must be high
    @(posedge clk); #0.5;
    for (int i = 0; i < 100; i++) begin
      if (clk_out === 1'b1) hi_ns++;
      #1;
    end
    n_cmp++;
    if (hi_ns != 50) begin
      n_bad++;
      $display("FAIL odd50_duty: high %0d ns of 100, required 50", hi_ns);
    end
    for (int i = 0; i < 10 && clk_out !== 1'b1; i++) begin
      @(negedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (clk_out !== 1'b0) begin
      n_bad++;
      $display("FAIL odd50_reset: clk_out=%b, required 0", clk_out);
    end
    rst = 1'b0;
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; div_in = '0;
    model_reset();
    test_reset();
    test_default();
    test_mid_load();
    test_wrap_load();
    test_illegal();
    test_enable();
    test_random();
    test_reset_mid();
`ifdef CLK_DIV_PROG_ODD50_EN
    test_odd50();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Runtime-programmable integer clock divider. Successor to the fixed-parameter divider.
- Adds a configurable counter width, synchronous reset and enable, and a divisor that can be changed at runtime. A new divisor takes effect only at a period boundary, so the output never glitches.
- Provides a one-cycle period tick plus status and error outputs for the control logic that programs it.
- Sits in the clock/timing utility set and drives slow strobes and derived clocks for peripherals.

Parameters:
- DIV_W, 16, width of the counter, the divisor input and the divisor status output.
- DIV_DEFAULT, 4, divisor in effect after reset. Must be in the range 2 .. 2**DIV_W-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count enable. When low, all counting state freezes.
- load  in  1  one-cycle strobe that requests a new divisor.
- div_in  in  DIV_W  requested divisor; sampled when load=1.
- clk_out  out  1  divided output, driven from a register.
- tick  out  1  one-cycle pulse in the clk cycle in which the counter wraps to 0.
- pend  out  1  a valid divisor is staged and waiting for the next wrap.
- err  out  1  one-cycle pulse when a load is rejected.
- div_cur  out  DIV_W  divisor currently in effect.

Behaviour:
- Internal state:
  - cnt[DIV_W], the period counter.
  - div_act, the active divisor.
  - div_shd, the shadow (staged) divisor.
  - pend flag.
- Reset: cnt=0, div_act=DIV_DEFAULT, div_shd=DIV_DEFAULT, pend=0, clk_out=0, tick=0, err=0. Reset overrides every other input, including a reset asserted mid-period or while a load is pending.
- Wrap condition: wrap = en & (cnt >= div_act-1). The >= comparison is deliberate; it keeps the counter safe even if div_act is smaller than cnt.
- Counter, when en=1:
  - On wrap: cnt <= 0.
  - Otherwise: cnt <= cnt+1.
- Counter, when en=0: cnt, clk_out and pend hold; tick=0.
- clk_out is registered. clk_out <= (cnt_next >= div_next>>1), where cnt_next and div_next are the post-edge values. Resulting shape:
  - Low for floor(D/2) cycles, then high for ceil(D/2) cycles.
  - Each period starts low.
- tick <= wrap. It is high exactly one cycle per period, aligned with cnt==0.
- Load handling:
  - Rejection: load=1 with div_in<2 is ignored and err pulses for 1 cycle. pend and div_shd are unchanged.
  - Load on a cycle without a wrap: div_shd <= div_in and pend <= 1. A second load while pend=1 overwrites the shadow; the last valid load wins.
  - Load on a cycle with a wrap: div_act <= div_in directly (bypass) and pend <= 0. The new divisor applies from the period starting at that wrap.
  - Wrap with no load and pend=1: div_act <= div_shd and pend <= 0.
- div_act never changes mid-period, so high and low phases are never truncated.
- div_cur = div_act.
- Latency from load to div_cur change: from 1 cycle up to D_old cycles, depending on the position in the period.
- Counter width: cnt never exceeds 2**DIV_W-2, so there is no overflow. A divisor of 2**DIV_W-1 is legal.

Optional Feature:
- Macro: CLK_DIV_PROG_ODD50_EN.
- Defined:
  - A negedge flop on clk captures the registered clk_out.
  - For odd div_act, the port is the AND of the posedge and negedge copies, giving exactly 50% duty (D/2 clk periods high and D/2 low).
  - For even div_act, the port equals the posedge register.
  - Reset clears the negedge flop synchronously, on the falling edge.
- Undefined: there is no negedge logic and the duty cycle is ceil/floor as described in Behaviour.

Decomposition:
- Package clk_div_pkg holds:
  - DIV_W_DEFAULT = 16.
  - DIV_MIN = 2.
  - A typedef for the divisor vector.
- One natural sub-module: clk_div_odd50, the negedge retimer plus odd-divisor select. It is instantiated only under CLK_DIV_PROG_ODD50_EN.

Test Plan:
- Reset defaults: rst held 3 cycles, then en=1 with DIV_DEFAULT=4. Required: clk_out sequence 0,0,1,1 repeating; tick every 4th cycle; div_cur=4.
- Mid-period load: load div_in=6 at cnt=1. Required: pend=1 until the wrap; the current period completes as 4 cycles; the next period is 3 low + 3 high; pend then drops; div_cur=6 after the wrap.
- Load coincident with wrap: load div_in=3 on the wrap cycle. Required: pend stays 0; the next period is 1 low + 2 high; tick spacing becomes 3.
- Illegal loads: load div_in=1, then div_in=0. Required: err pulses once per load; pend=0; output period unchanged.
- Enable gating: en=0 for 5 cycles at cnt=2. Required: clk_out, cnt and pend frozen; tick=0; the period resumes exactly where it stopped.
- Option on (CLK_DIV_PROG_ODD50_EN), div=5: required high and low times of 2.5 clk periods each. Reset asserted mid-high: clk_out=0 within 1 cycle.
